branch_predictor: RTL and testbench

- Fetch-side counterpart to the execute-stage branch resolution.
- Direct-mapped BTB with a 2-bit saturating direction counter per entry.
- Supplies a taken/target prediction to fetch each cycle. Execute reports the resolved outcome (taken flag from branch resolution plus the computed target); from that the block detects mispredicts, produces the redirect PC and trains the table.
- Keeps saturating branch and mispredict counters for performance reporting.

---
 rtl/branch_predictor.sv | 145 ++++++++++++++
 tb/tb_branch_predictor.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit direction counters
//
// Purpose: supplies a combinational taken/target prediction for the fetch PC,
// detects mispredicts when execute resolves a conditional branch, produces the
// redirect PC, trains the table and keeps saturating performance counters.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), synchronous active-high reset
//   i_fetch_pc            PC being fetched
//   o_pred_taken          predicted taken for i_fetch_pc
//   o_pred_target         predicted target (0 when not predicted taken)
//   i_upd_valid           a conditional branch resolves this cycle
//   i_upd_pc              PC of the resolving branch
//   i_upd_taken           resolved direction
//   i_upd_target          computed branch target
//   i_upd_pred_taken      prediction made at fetch, piped down
//   i_upd_pred_target     predicted target, piped down
//   o_mispredict          flush/redirect request
//   o_redirect_pc         correct next PC when o_mispredict=1, else 0
//   o_num_branches        saturating resolved-branch count
//   o_num_mispredicts     saturating mispredict count
module branch_predictor #(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 32 - INDEX_W - 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_fetch_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_pred_taken,
  input  logic [31:0] i_upd_pred_target,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_num_branches,
  output logic [31:0] o_num_mispredicts
);

  localparam int N = 1 << INDEX_W;

  logic [N-1:0]     valid_q;
  logic [TAG_W-1:0] tag_q    [N];
  logic [31:0]      target_q [N];
  logic [1:0]       ctr_q    [N];

  logic [31:0] num_branches_q, num_branches_d;
  logic [31:0] num_mispredicts_q, num_mispredicts_d;

  logic [INDEX_W-1:0] fetch_idx, upd_idx;
  logic [TAG_W-1:0]   fetch_tag, upd_tag;
  logic               fetch_hit, upd_hit;
  logic               upd_active;

  // Byte-offset bits never take part in lookup: PCs differing only there share an entry.
  logic unused_fetch_low;
  assign unused_fetch_low = ^i_fetch_pc[1:0];

  assign fetch_idx = i_fetch_pc[INDEX_W+1:2];
  assign fetch_tag = i_fetch_pc[31:INDEX_W+2];
  assign upd_idx   = i_upd_pc[INDEX_W+1:2];
  assign upd_tag   = i_upd_pc[31:INDEX_W+2];

  assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // An update during reset is ignored entirely, including its mispredict output.
  assign upd_active = i_upd_valid && !i_rst;

  // Lookup reads the pre-edge table contents, so a same-cycle update is not bypassed.
  always_comb begin
    o_pred_taken  = 1'b0;
    o_pred_target = 32'd0;
    if (!i_rst && fetch_hit && ctr_q[fetch_idx][1]) begin
      o_pred_taken  = 1'b1;
      o_pred_target = target_q[fetch_idx];
    end
  end

  always_comb begin
    o_mispredict  = 1'b0;
    o_redirect_pc = 32'd0;
    if (upd_active) begin
      // Direction wrong, or both taken but to different targets.
      o_mispredict = (i_upd_taken != i_upd_pred_taken) ||
                     (i_upd_taken && i_upd_pred_taken && (i_upd_target != i_upd_pred_target));
      if (o_mispredict) begin
        o_redirect_pc = i_upd_taken ? i_upd_target : (i_upd_pc + 32'd4);
      end
    end
  end

  always_comb begin
    num_branches_d    = num_branches_q;
    num_mispredicts_d = num_mispredicts_q;
    if (upd_active) begin
      if (num_branches_q != 32'hFFFF_FFFF) begin
        num_branches_d = num_branches_q + 32'd1;
      end
      if (o_mispredict && (num_mispredicts_q != 32'hFFFF_FFFF)) begin
        num_mispredicts_d = num_mispredicts_q + 32'd1;
      end
    end
  end

  // Tags and targets need no reset: they are only observed behind a valid bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q           <= '0;
      num_branches_q    <= 32'd0;
      num_mispredicts_q <= 32'd0;
      for (int i = 0; i < N; i++) begin
        ctr_q[i] <= 2'b00;
      end
    end else begin
      num_branches_q    <= num_branches_d;
      num_mispredicts_q <= num_mispredicts_d;
      if (i_upd_valid) begin
        if (upd_hit) begin
          if (i_upd_taken) begin
            if (ctr_q[upd_idx] != 2'b11) begin
              ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
            end
            target_q[upd_idx] <= i_upd_target;
          end else if (ctr_q[upd_idx] != 2'b00) begin
            ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
          end
        end else if (i_upd_taken) begin
          // Allocate weakly taken, evicting whatever aliased entry was resident.
          valid_q[upd_idx]  <= 1'b1;
          tag_q[upd_idx]    <= upd_tag;
          target_q[upd_idx] <= i_upd_target;
          ctr_q[upd_idx]    <= 2'b10;
        end
      end
    end
  end

  assign o_num_branches    = num_branches_q;
  assign o_num_mispredicts = num_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] num_branches;
  logic [31:0] num_mispredicts;

  int n_checks = 0;
  int n_errors = 0;

  branch_predictor dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_fetch_pc        (fetch_pc),
    .o_pred_taken      (pred_taken),
    .o_pred_target     (pred_target),
    .i_upd_valid       (upd_valid),
    .i_upd_pc          (upd_pc),
    .i_upd_taken       (upd_taken),
    .i_upd_target      (upd_target),
    .i_upd_pred_taken  (upd_pred_taken),
    .i_upd_pred_target (upd_pred_target),
    .o_mispredict      (mispredict),
    .o_redirect_pc     (redirect_pc),
    .o_num_branches    (num_branches),
    .o_num_mispredicts (num_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a 16-entry table with integer counters clamped to 0..3.
  bit          m_valid  [16];
  int unsigned m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  longint      m_nb;
  longint      m_nm;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == int'(pc >> 6));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 0;
    end
    m_nb = 0;
    m_nm = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic last_exp_mis;

  // One clock: drive inputs, check combinational outputs against the model,
  // take the edge, then advance the model.
  task automatic do_cycle(input logic r, input logic [31:0] fpc, input logic uv,
                          input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                          input logic upt, input logic [31:0] uptgt);
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_mis;
    logic [31:0] e_red;
    int          i;
    rst = r; fetch_pc = fpc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt;
    #2;
    e_pt   = !r && m_hit(fpc) && (m_ctr[m_idx(fpc)] >= 2);
    e_ptgt = e_pt ? m_target[m_idx(fpc)] : 32'd0;
    e_mis  = !r && uv && ((ut != upt) || (ut && upt && (utgt != uptgt)));
    e_red  = !e_mis ? 32'd0 : (ut ? utgt : upc + 32'd4);
    last_exp_mis = e_mis;
    check("pred_taken", {31'd0, pred_taken}, {31'd0, e_pt});
    check("pred_target", pred_target, e_ptgt);
    check("mispredict", {31'd0, mispredict}, {31'd0, e_mis});
    check("redirect_pc", redirect_pc, e_red);
    check("num_branches", num_branches, m_nb[31:0]);
    check("num_mispredicts", num_mispredicts, m_nm[31:0]);
    @(posedge clk);
    if (r) begin
      m_reset();
    end else if (uv) begin
      i = m_idx(upc);
      if (m_hit(upc)) begin
        if (ut) begin
          m_ctr[i]    = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
          m_target[i] = utgt;
        end else begin
          m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (ut) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = int'(upc >> 6);
        m_target[i] = utgt;
        m_ctr[i]    = 2;
      end
      m_nb = (m_nb + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_nb + 1;
      if (e_mis) m_nm = (m_nm + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_nm + 1;
    end
    #1;
  endtask

  task automatic idle(input logic [31:0] fpc);
    do_cycle(1'b0, fpc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic upd(input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                     input logic upt, input logic [31:0] uptgt);
    do_cycle(1'b0, 32'h0, 1'b1, upc, ut, utgt, upt, uptgt);
  endtask

  task automatic rst_cycles();
    do_cycle(1'b1, 32'h0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    do_cycle(1'b1, 32'h0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    logic [31:0] fpc, upc, utgt, uptgt;
    logic        ut, upt;
    m_reset();
    last_exp_mis = 1'b0;
    rst = 1'b1; fetch_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    @(posedge clk); #1;
    rst_cycles();

    // Reset state and first allocation.
    idle(32'h100);
    check("reset_pred", {31'd0, pred_taken}, 32'd0);
    upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    check("alloc_mispredict", {31'd0, last_exp_mis}, 32'd1);
    idle(32'h100);
    check("alloc_pred_target", pred_target, 32'h200);
    check("alloc_stats", num_mispredicts, 32'd1);

    // Counter walks down and floors at 0; one taken step leaves it at 1.
    upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
    idle(32'h100);
    upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    idle(32'h100);
    check("ctr_floor_pred", {31'd0, pred_taken}, 32'd0);

    // Aliasing at index 0.
    rst_cycles();
    upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    upd(32'h140, 1'b1, 32'h300, 1'b0, 32'h0);
    idle(32'h100);
    idle(32'h140);
    check("alias_target", pred_target, 32'h300);
    idle(32'h143);

    // Target change on a hit.
    rst_cycles();
    upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    upd(32'h100, 1'b1, 32'h280, 1'b1, 32'h200);
    idle(32'h100);
    check("new_target", pred_target, 32'h280);

    // Same-cycle fetch and update sees the old prediction.
    do_cycle(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h280);
    do_cycle(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(32'h100);

    // Reset wins over a same-cycle update.
    do_cycle(1'b1, 32'h100, 1'b1, 32'h180, 1'b1, 32'h400, 1'b0, 32'h0);
    idle(32'h180);
    check("rst_upd_stats", num_branches, 32'd0);

    // Saturation of the branch counter.
    force dut.num_branches_q = 32'hFFFF_FFFF;
    #1;
    release dut.num_branches_q;
    m_nb = 64'hFFFF_FFFF;
    upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(32'h100);
    check("branches_saturate", num_branches, 32'hFFFF_FFFF);

    // Randomized traffic over a small PC pool so hits and aliasing are frequent.
    rst_cycles();
    for (int n = 0; n < 3000; n++) begin
      fpc  = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      upc  = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) upc = 32'hFFFF_FFFC;
      ut   = 1'($urandom_range(0, 1));
      utgt = {$urandom_range(0, 7), 2'b00} + 32'h1000;
      upt  = !$urandom_range(0, 3) ? 1'($urandom_range(0, 1))
                                   : (m_hit(upc) && m_ctr[m_idx(upc)] >= 2);
      uptgt = upt ? (!$urandom_range(0, 3) ? utgt : m_target[m_idx(upc)]) : 32'd0;
      do_cycle(1'($urandom_range(0, 199) == 0), fpc, 1'($urandom_range(0, 2) != 0),
               upc, ut, utgt, upt, uptgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
